// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if -- hazard/stall controller bus.
// Groups the pipeline-side inputs (start, load-use operands, branch, memory
// handshake) with the controller's enable/bubble/flush/stall outputs.
//   master : pipeline side, drives the *_i signals and observes the *_o signals
//   slave  : controller side (pipe_stall_ctrl)
// stall_cycles_o / flush_cnt_o are live only when PIPE_STALL_CNT_EN is defined.
interface pipe_stall_ctrl_if;
  logic        start_i;
  logic        IDEX_MemRead_i;
  logic [4:0]  IDEX_RDaddr_i;
  logic [4:0]  IFID_RS1addr_i;
  logic [4:0]  IFID_RS2addr_i;
  logic        Branch_taken_i;
  logic        mem_req_i;
  logic        mem_ack_i;
  logic        PCWrite_o;
  logic        IFID_Write_o;
  logic        No_op_o;
  logic        Flush_o;
  logic        Stall_o;
  logic        err_o;
  logic [15:0] stall_cycles_o;
  logic [15:0] flush_cnt_o;

  modport master (
    output start_i, IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RS1addr_i, IFID_RS2addr_i,
           Branch_taken_i, mem_req_i, mem_ack_i,
    input  PCWrite_o, IFID_Write_o, No_op_o, Flush_o, Stall_o, err_o,
           stall_cycles_o, flush_cnt_o
  );

  modport slave (
    input  start_i, IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RS1addr_i, IFID_RS2addr_i,
           Branch_taken_i, mem_req_i, mem_ack_i,
    output PCWrite_o, IFID_Write_o, No_op_o, Flush_o, Stall_o, err_o,
           stall_cycles_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl -- pipeline stall / bubble / flush controller.
// Resolves memory wait > load-use hazard > taken branch each cycle and drives
// PC / IF-ID enables, a decode bubble, an IF-ID flush and a global stall.
// A memory access outstanding longer than TIMEOUT wait cycles locks the
// block in a sticky error state until reset.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-low reset
//   bus    : pipe_stall_ctrl_if.slave (inputs *_i, outputs *_o)
// Build option: define PIPE_STALL_CNT_EN to add saturating stall-cycle and
// flush counters; otherwise both count outputs read zero and no flops exist.
module pipe_stall_ctrl #(
  parameter int TIMEOUT = 255   // 1..255 memory-wait cycles before error
) (
  input  logic            clk_i,
  input  logic            rst_i,
  pipe_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_ERR} state_t;

  state_t     state;
  logic [7:0] wait_cnt;

  logic hazard, memwait;
  logic pc_we, ifid_we, no_op, flush, stall;

  assign hazard  = bus.IDEX_MemRead_i && (bus.IDEX_RDaddr_i != 5'd0) &&
                   ((bus.IDEX_RDaddr_i == bus.IFID_RS1addr_i) ||
                    (bus.IDEX_RDaddr_i == bus.IFID_RS2addr_i));
  assign memwait = bus.mem_req_i && !bus.mem_ack_i;

  // Outputs are Mealy in RUN/WAIT so a stall lands in the same cycle as its cause.
  always_comb begin
    pc_we   = 1'b0;
    ifid_we = 1'b0;
    no_op   = 1'b0;
    flush   = 1'b0;
    stall   = 1'b0;
    unique case (state)
      S_IDLE: no_op = 1'b1;
      S_ERR: begin
        no_op = 1'b1;
        stall = 1'b1;
      end
      default: begin
        if (memwait) begin
          stall = 1'b1;
        end else if (hazard) begin
          // a branch seen alongside a hazard is re-evaluated next cycle
          no_op = 1'b1;
        end else begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
          flush   = bus.Branch_taken_i;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      wait_cnt <= 8'd0;
    end else begin
      unique case (state)
        S_IDLE: if (bus.start_i) state <= S_RUN;
        S_RUN: if (memwait) begin
          state    <= S_WAIT;
          wait_cnt <= 8'd1;
        end
        S_WAIT: begin
          // an ack or an abandoned request both end the wait
          if (bus.mem_ack_i || !bus.mem_req_i) begin
            state    <= S_RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == 8'(TIMEOUT)) begin
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= S_ERR;
      endcase
    end
  end

  assign bus.PCWrite_o    = pc_we;
  assign bus.IFID_Write_o = ifid_we;
  assign bus.No_op_o      = no_op;
  assign bus.Flush_o      = flush;
  assign bus.Stall_o      = stall;
  assign bus.err_o        = (state == S_ERR);

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if ((state != S_IDLE) && (stall || no_op) && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (flush && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign bus.stall_cycles_o = stall_cnt;
  assign bus.flush_cnt_o    = flush_cnt;
`else
  assign bus.stall_cycles_o = 16'h0000;
  assign bus.flush_cnt_o    = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl -- directed-vector bench for pipe_stall_ctrl (TIMEOUT=4).
// Output vector packing: {err, Stall, Flush, No_op, IFID_Write, PCWrite}
//   IDLE / hazard 6'h04, RUN clear 6'h03, branch 6'h0B, memwait 6'h10, ERR 6'h34
module tb_pipe_stall_ctrl;
`ifdef PIPE_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [5:0] O_IDLE = 6'h04, O_HAZ = 6'h04, O_RUN = 6'h03,
                         O_BR = 6'h0B, O_MW = 6'h10, O_ERR = 6'h34;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errs   = 0;

  pipe_stall_ctrl_if bus();

  pipe_stall_ctrl #(.TIMEOUT(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  logic [5:0] outs;
  assign outs = {bus.err_o, bus.Stall_o, bus.Flush_o, bus.No_op_o,
                 bus.IFID_Write_o, bus.PCWrite_o};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic br, input logic req,
                     input logic ack);
    bus.IDEX_MemRead_i = mr;
    bus.IDEX_RDaddr_i  = rd;
    bus.IFID_RS1addr_i = rs1;
    bus.IFID_RS2addr_i = rs2;
    bus.Branch_taken_i = br;
    bus.mem_req_i      = req;
    bus.mem_ack_i      = ack;
  endtask

  // sample mid-cycle, then advance to just past the next rising edge
  task automatic step(input string tag, input logic [5:0] exp);
    @(negedge clk_i);
    chk(tag, 32'(outs), 32'(exp));
    @(posedge clk_i);
    #1;
  endtask

  // assert reset at the current time, check, release, then start the CPU
  task automatic rst_start(input string tag);
    rst_i = 1'b0;
    #1;
    chk({tag, "_rst_out"}, 32'(outs), 32'(O_IDLE));
    chk({tag, "_rst_stl"}, 32'(bus.stall_cycles_o), 32'h0);
    chk({tag, "_rst_fl"},  32'(bus.flush_cnt_o), 32'h0);
    drv(0, 0, 0, 0, 0, 0, 0);
    bus.start_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    bus.start_i = 1'b1;
    step({tag, "_idle_start"}, O_IDLE);
    bus.start_i = 1'b0;
  endtask

  initial begin
    bus.start_i = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_start("a");

    // group A: hazards and branches
    step("run_clear", O_RUN);
    drv(1, 5, 3, 5, 0, 0, 0); step("loaduse_rs2", O_HAZ);
    drv(0, 5, 3, 5, 0, 0, 0); step("after_bubble", O_RUN);
    drv(1, 0, 0, 7, 0, 0, 0); step("rd0_nobubble", O_RUN);
    drv(1, 7, 7, 1, 0, 0, 0); step("loaduse_rs1", O_HAZ);
    drv(1, 5, 6, 4, 0, 0, 0); step("nomatch", O_RUN);
    drv(0, 5, 5, 5, 0, 0, 0); step("noload_match", O_RUN);
    bus.start_i = 1'b1;
    drv(0, 0, 0, 0, 1, 0, 0); step("branch", O_BR);
    bus.start_i = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0); step("branch_1cyc", O_RUN);
    drv(1, 9, 9, 0, 1, 0, 0); step("branch_haz", O_HAZ);
    drv(1, 9, 9, 0, 1, 1, 0); step("prio_mw", O_MW);
    drv(0, 0, 0, 0, 0, 0, 0); step("abandon", O_RUN);
    step("abandon_run", O_RUN);
    chk("a_stall_cnt", 32'(bus.stall_cycles_o), CNT_EN ? 32'd4 : 32'd0);
    chk("a_flush_cnt", 32'(bus.flush_cnt_o),    CNT_EN ? 32'd1 : 32'd0);

    // group B: 3-cycle memory wait then ack
    rst_start("b");
    drv(0, 0, 0, 0, 0, 1, 1); step("zero_wait", O_RUN);
    drv(0, 0, 0, 0, 0, 1, 0); step("mw_c0", O_MW);
    step("mw_c1", O_MW);
    step("mw_c2", O_MW);
    drv(0, 0, 0, 0, 0, 1, 1); step("mw_ack", O_RUN);
    drv(0, 0, 0, 0, 0, 0, 0); step("mw_back_run", O_RUN);
    chk("b_stall_cnt", 32'(bus.stall_cycles_o), CNT_EN ? 32'd3 : 32'd0);

    // group C: timeout into sticky ERR
    rst_start("c");
    drv(0, 0, 0, 0, 0, 1, 0); step("to_run", O_MW);
    step("to_w1", O_MW);
    step("to_w2", O_MW);
    step("to_w3", O_MW);
    step("to_w4", O_MW);
    step("to_err", O_ERR);
    drv(0, 0, 0, 0, 0, 1, 1); step("err_ack", O_ERR);
    bus.start_i = 1'b1;
    drv(0, 0, 0, 0, 1, 0, 1); step("err_sticky", O_ERR);
    bus.start_i = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    rst_start("c_err");
    step("c_after_err", O_RUN);

    // group D: reset on the second wait cycle
    drv(0, 0, 0, 0, 0, 1, 0); step("d_run", O_MW);
    step("d_w1", O_MW);
    rst_start("d");
    step("d_no_residual", O_RUN);

    // group E: flush counter saturation
    rst_start("e");
    drv(0, 0, 0, 0, 1, 0, 0);
    repeat (65540) @(posedge clk_i);
    #1;
    step("e_branch", O_BR);
    chk("e_flush_sat", 32'(bus.flush_cnt_o),    CNT_EN ? 32'hFFFF : 32'd0);
    chk("e_stall_cnt", 32'(bus.stall_cycles_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 The block SHALL be parameterised as: TIMEOUT, 255, maximum memory-wait cycles before error (range 1..255).
REQ-002 The block SHALL have the following ports:
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  CPU start; leaves IDLE.
- IDEX_MemRead_i  in  1  instruction in EX is a load.
- IDEX_RDaddr_i  in  5  destination register of the instruction in EX.
- IFID_RS1addr_i  in  5  rs1 of the instruction in ID.
- IFID_RS2addr_i  in  5  rs2 of the instruction in ID.
- Branch_taken_i  in  1  ID-stage branch resolved taken.
- mem_req_i  in  1  MEM stage issuing a data-memory access.
- mem_ack_i  in  1  data memory completes the access this cycle.
- PCWrite_o  out  1  PC update enable.
- IFID_Write_o  out  1  IF/ID register enable.
- No_op_o  out  1  forces the main control decoder to emit all-zero control (bubble).
- Flush_o  out  1  clears IF/ID.
- Stall_o  out  1  freezes PC and all pipeline registers.
- err_o  out  1  sticky memory-timeout error.
- stall_cycles_o  out  16  stall-cycle count (macro only).
- flush_cnt_o  out  16  flush count (macro only).

Function
REQ-003 The FSM SHALL have four states: IDLE, RUN, WAIT, ERR; the state register and wait_cnt (8 bit) SHALL be the only mandatory sequential state.
REQ-004 The FSM SHALL leave IDLE for RUN on the clock edge where start_i=1 and ignore all other inputs in IDLE.
REQ-005 In IDLE the outputs SHALL be PCWrite_o=0, IFID_Write_o=0, No_op_o=1, Flush_o=0, Stall_o=0.
REQ-006 hazard SHALL be defined as IDEX_MemRead_i & (IDEX_RDaddr_i!=0) & (IDEX_RDaddr_i==IFID_RS1addr_i | IDEX_RDaddr_i==IFID_RS2addr_i).
REQ-007 memwait SHALL be defined as mem_req_i & ~mem_ack_i.
REQ-008 Outputs in RUN/WAIT SHALL be Mealy, in the same cycle, with priority memwait > hazard > branch.
REQ-009 When memwait=1, outputs SHALL be Stall_o=1, PCWrite_o=0, IFID_Write_o=0, No_op_o=0, Flush_o=0.
REQ-010 Otherwise, when hazard=1, outputs SHALL be PCWrite_o=0, IFID_Write_o=0, No_op_o=1, Flush_o=0; any simultaneous branch SHALL be ignored, since it is re-evaluated next cycle.
REQ-011 Otherwise, when Branch_taken_i=1, outputs SHALL be Flush_o=1 for exactly that cycle, with PCWrite_o=1 and IFID_Write_o=1.
REQ-012 With none of memwait, hazard or Branch_taken_i active, outputs SHALL be PCWrite_o=1, IFID_Write_o=1, others 0.
REQ-013 In RUN, memwait SHALL cause a transition to WAIT with wait_cnt<=1.
REQ-014 A zero-wait access (mem_req_i & mem_ack_i) SHALL stay in RUN with no stall.
REQ-015 In WAIT, mem_ack_i=1 SHALL return to RUN with wait_cnt<=0, and the ack cycle SHALL be unstalled.
REQ-016 In WAIT, mem_req_i dropping without ack SHALL also return to RUN (abandoned access).
REQ-017 In WAIT with no ack, wait_cnt SHALL increment; when wait_cnt==TIMEOUT and no ack arrives, the FSM SHALL enter ERR.
REQ-018 ERR SHALL be terminal until reset, with err_o=1, Stall_o=1, PCWrite_o=0, IFID_Write_o=0, No_op_o=1; ERR SHALL ignore mem_ack_i.
REQ-019 start_i SHALL be ignored outside IDLE.

Reset
REQ-020 rst_i=0 SHALL asynchronously force state=IDLE, wait_cnt=0, err_o=0, and both counters to 0.
REQ-021 Outputs SHALL take their IDLE values within the reset assertion.
REQ-022 Reset asserted mid-WAIT or in ERR SHALL abandon the access with no residual stall after release.
REQ-023 Release SHALL be synchronised by the integrating design; the block's first active edge after release SHALL evaluate from IDLE.

Configuration
REQ-024 With macro PIPE_STALL_CNT_EN defined, stall_cycles_o SHALL count cycles with Stall_o=1 or No_op_o=1 outside IDLE, saturating at 16'hFFFF.
REQ-025 With PIPE_STALL_CNT_EN defined, flush_cnt_o SHALL count cycles with Flush_o=1, saturating at 16'hFFFF.
REQ-026 Without PIPE_STALL_CNT_EN, stall_cycles_o and flush_cnt_o SHALL be tied to 16'h0000, no counter flops SHALL be synthesised, and all other behaviour SHALL be identical.

Verification
REQ-027 The bench SHALL cover load-use: RUN, IDEX_MemRead_i=1, RDaddr=5, RS2=5 -> one cycle No_op_o=1, PCWrite_o=0; RDaddr=0 with RS1=0 -> no bubble.
REQ-028 The bench SHALL cover branch: Branch_taken_i=1, no hazard -> Flush_o=1 for 1 cycle; Branch_taken_i=1 with hazard -> No_op_o=1, Flush_o=0.
REQ-029 The bench SHALL cover memory wait: mem_req_i=1, ack after 3 cycles -> Stall_o=1 for 3 cycles, 0 on the ack cycle, state RUN; stall_cycles_o=3 with the macro.
REQ-030 The bench SHALL cover timeout: TIMEOUT=4, mem_req_i=1, ack never arrives -> ERR entered after 4 WAIT cycles, err_o=1 sticky; a later ack -> no change.
REQ-031 The bench SHALL cover reset mid-WAIT: rst_i=0 on the 2nd wait cycle -> immediate IDLE outputs, err_o=0; after release and start_i -> normal RUN.
REQ-032 The bench SHALL cover saturation: with the macro, force 65540 flushes -> flush_cnt_o=16'hFFFF; without the macro -> 0.
